execute_stage: RTL and testbench

//  Consumer end of the decode->execute bus. Takes idbus (op, dst, r1, r2, imm) from decode_stage,

---
 rtl/ex_pkg.sv | 35 +++
 rtl/ex_multiplier.sv | 58 +++++
 rtl/execute_stage.sv | 136 +++++++++++++
 tb/tb_execute_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, idbus/exbus field layout, MUL FSM states.
// The iterative multiplier is built only when EX_MUL_EN is defined.
package ex_pkg;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_ANDI = 4'd5;
    localparam logic [3:0] OP_ORI  = 4'd6;
    localparam logic [3:0] OP_SLTI = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;

    localparam int ID_W       = 106;
    localparam int ID_VALID   = 105;
    localparam int ID_OP_LSB  = 101;
    localparam int ID_DST_LSB = 96;
    localparam int ID_R1_LSB  = 64;
    localparam int ID_R2_LSB  = 32;
    localparam int ID_IMM_LSB = 0;

    localparam int EX_W       = 74;
    localparam int EX_VALID   = 73;
    localparam int EX_OP_LSB  = 69;
    localparam int EX_DST_LSB = 64;
    localparam int EX_RES_LSB = 32;
    localparam int EX_SD_LSB  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/ex_multiplier.sv
// Iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle (low 32 bits of a*b).
// done is combinational so the last step and the consumer's capture of p share one edge.
module ex_multiplier #(
    parameter int MUL_BPC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] p
);
    localparam int MUL_STEPS = 32 / MUL_BPC;
    localparam int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      acc;
    logic [31:0]      a_sh;
    logic [31:0]      b_sh;
    logic [31:0]      partial;
    logic [31:0]      acc_next;

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (b_sh[j]) partial = partial + (a_sh << j);
        end
        acc_next = acc + partial;
    end

    assign done = running && (cnt == CNT_W'(MUL_STEPS - 1));
    assign p    = acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            a_sh    <= a;
            b_sh    <= b;
        end else if (running) begin
            acc  <= acc_next;
            a_sh <= a_sh << MUL_BPC;
            b_sh <= b_sh >> MUL_BPC;
            cnt  <= cnt + 1'b1;
            if (done) running <= 1'b0;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU/address compute from idbus into the registered exbus.
// Define EX_MUL_EN to build the iterative MUL path; otherwise op 0011 is a single-cycle AND.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | sampling idbus every cycle, single-cycle ops go straight out
//  ST_MUL  | multiply in flight, idbus ignored, ex_busy high
module execute_stage
    import ex_pkg::*;
#(
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ID_W-1:0] idbus,
    output logic            ex_busy,
    output logic [4:0]      ex_dst,
    output logic [EX_W-1:0] exbus
);
    if ((MUL_BPC != 1) && (MUL_BPC != 2) && (MUL_BPC != 4) && (MUL_BPC != 8)) begin : g_bad_bpc
        $error("MUL_BPC must be 1, 2, 4 or 8");
    end

    logic        id_valid;
    logic [3:0]  id_op;
    logic [4:0]  id_dst;
    logic [31:0] id_r1;
    logic [31:0] id_r2;
    logic [31:0] id_imm;

    assign id_valid = idbus[ID_VALID];
    assign id_op    = idbus[ID_OP_LSB +: 4];
    assign id_dst   = idbus[ID_DST_LSB +: 5];
    assign id_r1    = idbus[ID_R1_LSB +: 32];
    assign id_r2    = idbus[ID_R2_LSB +: 32];
    assign id_imm   = idbus[ID_IMM_LSB +: 32];

    logic            alu_valid;
    logic [31:0]     alu_res;
    logic [31:0]     alu_sdata;
    logic [EX_W-1:0] alu_bus;

    always_comb begin
        alu_valid = id_valid;
        alu_res   = '0;
        alu_sdata = '0;
        case (id_op)
            OP_ADD:  alu_res = id_r1 + id_r2;
            OP_SUB:  alu_res = id_r1 - id_r2;
`ifndef EX_MUL_EN
            OP_MUL:  alu_res = id_r1 & id_r2;
`endif
            OP_ADDI: alu_res = id_r1 + id_imm;
            OP_ANDI: alu_res = id_r1 & id_imm;
            OP_ORI:  alu_res = id_r1 | id_imm;
            OP_SLTI: alu_res = {31'b0, $signed(id_r1) < $signed(id_imm)};
            OP_LW:   alu_res = id_r1 + id_imm;
            OP_SW: begin
                alu_res   = id_r1 + id_imm;
                alu_sdata = id_r2;
            end
            default: alu_valid = 1'b0;
        endcase
    end

    // Bubbles and non-issuing ops leave every exbus field at zero.
    assign alu_bus = alu_valid ? {1'b1, id_op, id_dst, alu_res, alu_sdata} : '0;

`ifdef EX_MUL_EN
    mul_state_e      state_q;
    mul_state_e      state_d;
    logic [4:0]      mul_dst_q;
    logic            mul_start;
    logic            mul_done;
    logic [31:0]     mul_p;
    logic [EX_W-1:0] exbus_d;

    ex_multiplier #(.MUL_BPC(MUL_BPC)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (id_r1),
        .b     (id_r2),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        exbus_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (id_valid && (id_op == OP_MUL)) begin
                    state_d   = ST_MUL;
                    mul_start = 1'b1;
                end else begin
                    exbus_d = alu_bus;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_IDLE;
                    exbus_d = {1'b1, OP_MUL, mul_dst_q, mul_p, 32'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mul_dst_q <= '0;
            exbus     <= '0;
        end else begin
            state_q <= state_d;
            exbus   <= exbus_d;
            if (mul_start) mul_dst_q <= id_dst;
        end
    end

    assign ex_busy = (state_q == ST_MUL);
    assign ex_dst  = ex_busy ? mul_dst_q :
                     (exbus[EX_VALID] ? exbus[EX_DST_LSB +: 5] : 5'd0);
`else
    always_ff @(posedge clk) begin
        if (reset) exbus <= '0;
        else       exbus <= alu_bus;
    end

    assign ex_busy = 1'b0;
    assign ex_dst  = exbus[EX_VALID] ? exbus[EX_DST_LSB +: 5] : 5'd0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus random instructions scored
// against a plain-arithmetic reference model; follows EX_MUL_EN the same way as the RTL.
`timescale 1ns/1ps
module tb_execute_stage;
    localparam int MUL_BPC = 1;
    localparam int STEPS   = 32 / MUL_BPC;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [105:0] idbus = '0;
    logic         ex_busy;
    logic [4:0]   ex_dst;
    logic [73:0]  exbus;

    execute_stage #(.MUL_BPC(MUL_BPC)) dut (
        .clk     (clk),
        .reset   (reset),
        .idbus   (idbus),
        .ex_busy (ex_busy),
        .ex_dst  (ex_dst),
        .exbus   (exbus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [73:0] bus;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(string name, logic [73:0] act, logic [73:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [73:0] model(logic v, logic [3:0] op, logic [4:0] dst,
                                          logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
        logic [31:0] res = 32'd0;
        logic [31:0] sd  = 32'd0;
        bit          ok  = 1'b1;
        case (op)
            4'd1: res = r1 + r2;
            4'd2: res = r1 - r2;
`ifdef EX_MUL_EN
            4'd3: res = r1 * r2;
`else
            4'd3: res = r1 & r2;
`endif
            4'd4: res = r1 + imm;
            4'd5: res = r1 & imm;
            4'd6: res = r1 | imm;
            4'd7: res = (int'(r1) < int'(imm)) ? 32'd1 : 32'd0;
            4'd8: res = r1 + imm;
            4'd9: begin res = r1 + imm; sd = r2; end
            default: ok = 1'b0;
        endcase
        return (v && ok) ? {1'b1, op, dst, res, sd} : 74'd0;
    endfunction

    task automatic send(logic v, logic [3:0] op, logic [4:0] dst,
                        logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
        logic [73:0] e;
        bit          is_mul;
        int          c;
        @(negedge clk);
        idbus  = {v, op, dst, r1, r2, imm};
        c      = cyc;
        e      = model(v, op, dst, r1, r2, imm);
        is_mul = 1'b0;
`ifdef EX_MUL_EN
        is_mul = v && (op == 4'd3);
`endif
        if (is_mul) begin
            sb.push_back('{e, c + 1 + STEPS});
            @(posedge clk);
            for (int k = 0; k < STEPS; k++) begin
                #1;
                chk("mul_busy", 74'(ex_busy), 74'(1));
                chk("mul_ex_dst", 74'(ex_dst), 74'(dst));
                chk("mul_exbus_zero", exbus, 74'(0));
                // decode-side noise while busy must never be sampled
                if (k == 0)
                    idbus = {1'($urandom_range(0, 1)), 4'd1, 5'($urandom), $urandom, $urandom, $urandom};
                @(posedge clk);
            end
            #1;
            chk("mul_busy_end", 74'(ex_busy), 74'(0));
        end else begin
            if (e[73]) sb.push_back('{e, c + 1});
            @(posedge clk);
            #1;
            chk("busy_low", 74'(ex_busy), 74'(0));
            if (!e[73]) begin
                chk("bubble_exbus", exbus, 74'(0));
                chk("bubble_ex_dst", 74'(ex_dst), 74'(0));
            end
        end
    endtask

    task automatic mul_reset_test();
        @(negedge clk);
        idbus = {1'b1, 4'd3, 5'd9, 32'h0000_1234, 32'h0000_5678, 32'h0};
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_busy", 74'(ex_busy), 74'(1));
        @(negedge clk);
        reset = 1'b1;
        idbus = '0;
        @(posedge clk);
        #1;
        chk("abort_busy", 74'(ex_busy), 74'(0));
        chk("abort_exbus", exbus, 74'(0));
        chk("abort_ex_dst", 74'(ex_dst), 74'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every valid exbus beat must match the oldest expectation, on its due cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exbus[73] === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h expected no output (cycle %0d)", exbus, cyc);
                end else begin
                    x = sb.pop_front();
                    chk("exbus", exbus, x.bus);
                    chk("ex_dst", 74'(ex_dst), 74'(x.bus[68:64]));
                    chk("latency", 74'(cyc), 74'(x.due));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_exbus", exbus, 74'(0));
        chk("reset_busy", 74'(ex_busy), 74'(0));
        chk("reset_ex_dst", 74'(ex_dst), 74'(0));
        @(negedge clk);
        reset = 1'b0;

        send(1'b1, 4'd1, 5'd3, 32'd5, 32'd7, 32'd0);
        send(1'b1, 4'd2, 5'd1, 32'd3, 32'd5, 32'd0);
        send(1'b1, 4'd7, 5'd2, 32'hFFFF_FFFF, 32'd0, 32'd0);
        send(1'b1, 4'd6, 5'd7, 32'h0000_00F0, 32'd0, 32'h0000_000F);
        send(1'b1, 4'd9, 5'd0, 32'h0000_0100, 32'h0000_00AB, 32'hFFFF_FFFC);
        send(1'b1, 4'd11, 5'd4, 32'd1, 32'd1, 32'd8);
        send(1'b0, 4'd1, 5'd5, 32'd1, 32'd2, 32'd3);
        send(1'b1, 4'd8, 5'd6, 32'h8000_0000, 32'd1, 32'h8000_0004);
`ifdef EX_MUL_EN
        send(1'b1, 4'd3, 5'd4, 32'h0000_FFFF, 32'h0001_0001, 32'd0);
        send(1'b1, 4'd1, 5'd5, 32'd10, 32'd20, 32'd0);
        send(1'b1, 4'd3, 5'd8, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
        send(1'b1, 4'd3, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        mul_reset_test();
        send(1'b1, 4'd1, 5'd11, 32'd100, 32'd23, 32'd0);
`else
        send(1'b1, 4'd3, 5'd6, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
`endif

        for (int i = 0; i < 150; i++) begin
            send(1'($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), 5'($urandom),
                 $urandom, $urandom, $urandom);
        end

        repeat (3) send(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        chk("scoreboard_drained", 74'(sb.size()), 74'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
